// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: receive FSM state encoding, the oversampling
//   ratio and the baud divisor helper. The divisor helper is also used by
//   the TX side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clock cycles per oversample tick, truncated.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//   Free-running divider producing a one-cycle tick every DIV clocks.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-low reset
//     clr   in   restart the divider (tick phase realigns to this cycle)
//     tick  out  one-cycle pulse every DIV cycles
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == LAST);
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os16.sv
// ---------------------------------------------------------------------------
// uart_rx_os16
//   8-N-1 UART receiver, LSB first, 16x oversampling with mid-bit sampling.
//   Rejects false starts, flags framing errors and FIFO-full overruns.
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous active-low reset
//     rx           in   asynchronous serial line, idles high
//     fifo_full    in   downstream FIFO full; sampled only in the strobe cycle
//     rx_data      out  last good byte; holds until the next good byte
//     rx_valid     out  one-cycle push strobe, rx_data valid in same cycle
//     frame_err    out  one-cycle pulse when the stop bit samples 0
//     overrun_err  out  one-cycle pulse when a good byte meets fifo_full
//     busy         out  high whenever the FSM is not IDLE
//     dbg_state    out  current FSM state
//
//   Handshake: rx_valid is a push-only strobe with no ready; fifo_full acts
//   as the inverse ready and is only looked at in the cycle the byte would
//   be pushed. rx_valid, frame_err and overrun_err never assert together.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16           // only 16 is supported
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                fifo_full,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                busy,
  output uart_pkg::rx_state_t dbg_state
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLK_HZ, BAUD);

  logic       rx_meta_q, rx_s_q;
  rx_state_t  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       tick, tick_clr;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (!rx_s_q) begin
          state_d  = START;
          tick_clr = 1'b1;          // align tick phase to the start edge
        end
      end
      START: if (tick) begin
        if (tcnt_q == 4'd7) begin   // middle of the start bit
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;     // wraps 15 -> 0 at each bit centre
        if (tcnt_q == 4'd15) begin
          sr_d   = {rx_s_q, sr_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          if (rx_s_q) begin
            if (fifo_full) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = sr_q;
              valid_d = 1'b1;
            end
            state_d = IDLE;         // leaves half a bit to catch next start
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os16
//   Directed bench. The clock is scaled so one tick is 10 cycles
//   (CLK_HZ = 1.536 MHz nominal, 10 ns simulated period): one bit is
//   160 cycles = 1600 ns. Test-plan times are scaled by the same ratio.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_os16;
  import uart_pkg::*;

  localparam int CLK_HZ   = 1_536_000;
  localparam int BAUD     = 9600;
  localparam int CYC_NS   = 10;
  localparam int BIT_NS   = 1600;   // 16 ticks * 10 cycles * 10 ns
  localparam int BIT_SLOW = 1648;   // +3 %
  localparam int BIT_FAST = 1552;   // -3 %

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;
  rx_state_t  dbg_state;

  always #5 clk = ~clk;

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .fifo_full   (fifo_full),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         valid_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  longint     last_lat = 0;
  time        last_fall_t = 0;
  int         v0, f0, o0;

  logic [7:0] t1_bytes [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Leaves rx at the stop-bit level so a 0 stop bit can run into a break.
  task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_bit);
    rx = 1'b0;
    last_fall_t = $time;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rx_valid || frame_err || overrun_err)
      check("pulse_excl", 32'(rx_valid) + 32'(frame_err) + 32'(overrun_err), 32'd1);
    if (frame_err)   fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (rx_valid) begin
      valid_cnt++;
      last_lat = longint'(($time - last_fall_t) / CYC_NS);
      if (exp_q.size() == 0) check("spurious_valid_q_depth", 32'd0, 32'd1);
      else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // back-to-back bytes
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(t1_bytes[i]);
      send_byte(t1_bytes[i], BIT_NS, 1'b1);
    end
    #(2 * BIT_NS);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd5);
    check("b2b_ferr_cnt", 32'(fe_cnt), 32'd0);
    check("b2b_ovr_cnt", 32'(ov_cnt), 32'd0);
    check("b2b_q_left", 32'(exp_q.size()), 32'd0);
    // edge at negedge t: sync 2 clks, START at t+25ns, 152 ticks of 10 clks
    check("strobe_lat_cyc", 32'(last_lat), 32'd1523);

    // glitch: about 3 % of a bit low
    v0 = valid_cnt; f0 = fe_cnt;
    rx = 1'b0;
    #50;
    rx = 1'b1;
    #550;
    check("glitch_busy_hi", 32'(busy), 32'd1);
    #400;
    check("glitch_busy_lo", 32'(busy), 32'd0);
    #(BIT_NS);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);

    // framing error followed by a held-low break, then a good byte
    v0 = valid_cnt; f0 = fe_cnt;
    send_byte(8'h55, BIT_NS, 1'b0);
    #(5 * BIT_NS);
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_state", 32'(dbg_state), 32'(BREAK));
    rx = 1'b1;
    #(2 * BIT_NS);
    check("brk_ferr_once", 32'(fe_cnt - f0), 32'd1);
    check("brk_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("brk_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h41);
    send_byte(8'h41, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    check("post_brk_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_brk_ferr", 32'(fe_cnt - f0), 32'd1);

    // overrun: byte arrives while FIFO is full
    v0 = valid_cnt; o0 = ov_cnt;
    fifo_full = 1'b1;
    send_byte(8'hA5, BIT_NS, 1'b1);
    fifo_full = 1'b0;
    #(BIT_NS);
    check("ovr_pulse", 32'(ov_cnt - o0), 32'd1);
    check("ovr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ovr_data_held", 32'(rx_data), 32'h41);

    // reset mid-frame during data bit 4 of 0xFF
    v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    last_fall_t = $time;
    #(BIT_NS);
    rx = 1'b1;
    #(4 * BIT_NS + BIT_NS / 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    #(5 * BIT_NS);
    check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("mid_rst_no_ferr", 32'(fe_cnt - f0), 32'd0);
    check("mid_rst_no_ovr", 32'(ov_cnt - o0), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_data", 32'(rx_data), 32'h3C);

    // +3 % and -3 % line rate
    v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h00, BIT_SLOW, 1'b1);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, BIT_SLOW, 1'b1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, BIT_FAST, 1'b1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, BIT_FAST, 1'b1);
    #(2 * BIT_NS);
    check("tol_valid_cnt", 32'(valid_cnt - v0), 32'd4);
    check("tol_ferr", 32'(fe_cnt - f0), 32'd0);
    check("tol_ovr", 32'(ov_cnt - o0), 32'd0);

    check("final_q_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

UART receive front end that turns the serial `rx` line into bytes for the receive FIFO. It sits directly after the board `rx` pin and feeds the FIFO push port of the loopback design. It uses 8-N-1 framing, LSB first, with 16× oversampling and mid-bit sampling. Line faults are flagged: false starts are rejected, framing errors and FIFO-full overruns are reported.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate.
- `OVERSAMPLE`, 16: ticks per bit. Fixed; other values are unsupported.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-low: while 0 at a rising `clk` edge, the block resets.
- `rx`  in  1  asynchronous serial line; idles high.
- `fifo_full`  in  1  FIFO full flag; when high, a received byte is not pushed.
- `rx_data`  out  8  last received byte; holds until the next good byte.
- `rx_valid`  out  1  one-cycle push strobe; `rx_data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun_err`  out  1  one-cycle pulse when a good byte is dropped because `fifo_full`=1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: 2 flip-flops on `rx`, both reset to 1. All decisions use the synchronized value `rx_s`.
- Tick divisor: `DIV = CLK_HZ/(BAUD*16)`, integer-truncated (651 at the defaults).
  - Counter width is `$clog2(DIV)`.
  - `tick` pulses for 1 cycle every `DIV` cycles.
  - The counter is cleared when IDLE→START occurs, so samples align to the start edge.
- Counters: tick counter `tcnt` (4 bits) and bit counter `bcnt` (3 bits). Shift register `sr` (8 bits) shifts right, inserting the new bit at `sr[7]`.
- FSM states and transitions:
  - IDLE: on `rx_s`=0 → START; `tcnt`=0.
  - START: on the 8th tick, sample `rx_s`.
    - 0 → DATA with `tcnt`=0 and `bcnt`=0.
    - 1 → IDLE (false start; no output, no flag).
  - DATA: on each 16th tick, shift in `rx_s`. After `bcnt`=7 is shifted → STOP.
  - STOP: on the 16th tick, sample `rx_s`.
    - 1 and `fifo_full`=0: `rx_data`←`sr`, pulse `rx_valid`, go to IDLE.
    - 1 and `fifo_full`=1: pulse `overrun_err`. `rx_data` is not updated. Go to IDLE.
    - 0: pulse `frame_err`, go to BREAK.
  - BREAK: wait until `rx_s`=1, then → IDLE. A held-low line (break) produces exactly one `frame_err`.
- `rx_valid`, `frame_err` and `overrun_err` are mutually exclusive.

## Timing
- Reset values:
  - `rx_data`=0x00.
  - `rx_valid`, `frame_err`, `overrun_err`, `busy` = 0.
  - FSM in IDLE; synchronizer flops = 1; all counters = 0.
- Reset mid-frame: the frame in progress is discarded and no strobe is emitted. Operation resumes at the first falling edge after release.
- Start detection latency: 2–3 cycles after the `rx` falling edge.
- Strobe time: `rx_valid` (or the error pulse) is registered at (8 + 8·16 + 16)·`DIV` = 98,952 cycles after start detection, i.e. mid-stop-bit, about 989.5 µs at the defaults.
- Back-to-back frames: returning to IDLE mid-stop-bit leaves about 0.5 bit of margin, so the next start edge is caught with no dead time.
- `fifo_full` is sampled only in the strobe cycle.
- Baud tolerance: correct reception is required for a line rate error of ±3%.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - `OVERSAMPLE`=16;
  - the divisor function `baud_div(clk_hz, baud)`, which is shared with the TX side.
- Sub-module `baud_tick_gen` (parameter `DIV`; ports `clk`, `rst`, `clr`, `tick`) is instantiated once. The TX path reuses the same sub-module.
- The synchronizer, FSM, counters and shift register live in `uart_rx_os16`.

## Test plan
- Back-to-back bytes 0x30, 0x31, 0x32, 0x33, 0x34 at a 104,167 ns bit period, `fifo_full`=0 → exactly 5 `rx_valid` pulses with `rx_data` = 0x30 … 0x34 in order, and no error pulses.
- A 3 µs low glitch on an idle line → `busy` rises, then returns to 0 about 52 µs later. No `rx_valid` and no `frame_err`.
- Byte 0x55 with the stop bit driven 0, the line held low for 500 µs, then 0x41 sent → one `frame_err`, no `rx_valid` for 0x55, then `rx_valid` with 0x41.
- `fifo_full`=1 during byte 0xA5 → one `overrun_err` pulse, no `rx_valid`, and `rx_data` keeps its previous value.
- `rst`=0 for 1 cycle during data bit 4 of 0xFF → all outputs return to reset values with no strobe. A following 0x3C is then received correctly.
- Bit period of 107,292 ns (+3%) with bytes 0x00 and 0xFF → both received correctly with no errors.
